// File: rtl/prod_acc.sv
// Frame accumulator for 16-bit unsigned multiplier products, with valid/ready on both sides.
// Optional saturating accumulate when PROD_ACC_SAT_EN is defined; otherwise the sum wraps.
module prod_acc #(
  parameter int ACC_W = 24,
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      prod_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  // state   | meaning
  // ST_ACC  | accepting products, in_ready=1, out_valid=0
  // ST_HOLD | frame result presented, in_ready=0, out_valid=1
  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_ext;
  logic             carry;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_ext = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, prod_i};
    carry   = sum_ext[ACC_W];
    unique case (state_q)
      ST_ACC: begin
        if (in_valid_i) begin
`ifdef PROD_ACC_SAT_EN
          // Once saturated, any further nonzero product carries again and stays pinned.
          acc_d = carry ? '1 : sum_ext[ACC_W-1:0];
`else
          acc_d = sum_ext[ACC_W-1:0];
`endif
          ovf_d = ovf_q | carry;
          if (cnt_q == CNT_W'(LEN-1)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          state_d = ST_ACC;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  assign in_ready_o  = (state_q == ST_ACC) && !rst_i;
  assign out_valid_o = (state_q == ST_HOLD);
  assign sum_o       = acc_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_prod_acc.sv
// Directed bench for prod_acc: three instances (24-bit/LEN=4, 17-bit/LEN=4, LEN=1) driven in turn.
module tb_prod_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        va = 0, ora = 0;  logic [15:0] pa = 0;
  logic        ira, ova, ofa;    logic [23:0] sa;
  logic        vw = 0, orw = 0;  logic [15:0] pw = 0;
  logic        irw, ovw, ofw;    logic [16:0] sw;
  logic        vl = 0, orl = 0;  logic [15:0] pl = 0;
  logic        irl, ovl, ofl;    logic [23:0] sl;

  prod_acc #(.ACC_W(24), .LEN(4), .CNT_W(8)) u_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(va), .in_ready_o(ira), .prod_i(pa),
    .out_valid_o(ova), .out_ready_i(ora), .sum_o(sa), .ovf_o(ofa));
  prod_acc #(.ACC_W(17), .LEN(4), .CNT_W(8)) u_w (
    .clk_i(clk), .rst_i(rst), .in_valid_i(vw), .in_ready_o(irw), .prod_i(pw),
    .out_valid_o(ovw), .out_ready_i(orw), .sum_o(sw), .ovf_o(ofw));
  prod_acc #(.ACC_W(24), .LEN(1), .CNT_W(8)) u_l (
    .clk_i(clk), .rst_i(rst), .in_valid_i(vl), .in_ready_o(irl), .prod_i(pl),
    .out_valid_o(ovl), .out_ready_i(orl), .sum_o(sl), .ovf_o(ofl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] vec_a [4] = '{16'd3, 16'd5, 16'd7, 16'd9};
  logic [15:0] vec_b [4] = '{16'd1000, 16'd2000, 16'd3000, 16'd4000};
  int ov_cnt;
  logic [31:0] sat_exp;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_in_ready", {31'd0, ira}, 32'd0);
    chk("rst_out_valid", {31'd0, ova}, 32'd0);
    chk("rst_sum", {8'd0, sa}, 32'd0);
    chk("rst_ovf", {31'd0, ofa}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, ira}, 32'd1);

    // Basic frame 3,5,7,9 back to back
    ora = 1'b1;
    for (int i = 0; i < 4; i++) begin
      va = 1'b1; pa = vec_a[i];
      tick();
      if (i == 1) chk("basic_mid_sum", {8'd0, sa}, 32'd8);
      if (i < 3) chk("basic_no_ov", {31'd0, ova}, 32'd0);
    end
    va = 1'b0;
    chk("basic_ov", {31'd0, ova}, 32'd1);
    chk("basic_sum", {8'd0, sa}, 32'd24);
    chk("basic_ovf", {31'd0, ofa}, 32'd0);
    chk("basic_hold_in_ready", {31'd0, ira}, 32'd0);
    tick();
    chk("basic_ov_one_cycle", {31'd0, ova}, 32'd0);
    chk("basic_in_ready_back", {31'd0, ira}, 32'd1);
    chk("basic_cleared", {8'd0, sa}, 32'd0);

    // Backpressure with gaps; in_valid pulses in HOLD must be ignored
    ora = 1'b0;
    for (int i = 0; i < 4; i++) begin
      va = 1'b1; pa = vec_b[i];
      tick();
      va = 1'b0; pa = 16'hDEAD;
      if (i < 3) tick();
    end
    chk("bp_ov", {31'd0, ova}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      va = c[0]; pa = 16'h5555;
      tick();
      chk("bp_hold_sum", {8'd0, sa}, 32'd10000);
      chk("bp_hold_ov", {31'd0, ova}, 32'd1);
      chk("bp_hold_in_ready", {31'd0, ira}, 32'd0);
    end
    va = 1'b0; ora = 1'b1;
    tick();
    chk("bp_release_ov", {31'd0, ova}, 32'd0);
    chk("bp_release_sum", {8'd0, sa}, 32'd0);

    // Reset mid-frame: partial frame dropped, exactly one result afterwards
    ov_cnt = 0;
    va = 1'b1; pa = 16'd100; tick(); ov_cnt += int'(ova);
    pa = 16'd200; tick(); ov_cnt += int'(ova);
    va = 1'b0; rst = 1'b1; tick(); ov_cnt += int'(ova);
    chk("mrst_sum", {8'd0, sa}, 32'd0);
    chk("mrst_in_ready", {31'd0, ira}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      va = 1'b1; pa = 16'd1; tick(); ov_cnt += int'(ova);
    end
    va = 1'b0;
    chk("mrst_sum_new", {8'd0, sa}, 32'd4);
    tick(); ov_cnt += int'(ova);
    tick(); ov_cnt += int'(ova);
    chk("mrst_result_count", ov_cnt, 32'd1);

    // 17-bit overflow: four 0xFFFF
`ifdef PROD_ACC_SAT_EN
    sat_exp = 32'h1FFFF;
`else
    sat_exp = 32'h1FFFC;
`endif
    orw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vw = 1'b1; pw = 16'hFFFF; tick();
    end
    vw = 1'b0;
    chk("ovf_sum", {15'd0, sw}, sat_exp);
    chk("ovf_flag", {31'd0, ofw}, 32'd1);
    chk("ovf_ov", {31'd0, ovw}, 32'd1);
    orw = 1'b1; tick(); orw = 1'b0;
    chk("ovf_cleared", {31'd0, ofw}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      vw = 1'b1; pw = 16'd1; tick();
    end
    vw = 1'b0;
    chk("ovf_next_sum", {15'd0, sw}, 32'd4);
    chk("ovf_next_flag", {31'd0, ofw}, 32'd0);
    orw = 1'b1; tick(); orw = 1'b0;

    // LEN=1: 7 then 9, in_ready pattern 1,0,1,0
    orl = 1'b1;
    chk("len1_rdy0", {31'd0, irl}, 32'd1);
    vl = 1'b1; pl = 16'd7; tick();
    chk("len1_rdy1", {31'd0, irl}, 32'd0);
    chk("len1_ov_a", {31'd0, ovl}, 32'd1);
    chk("len1_sum_a", {8'd0, sl}, 32'd7);
    pl = 16'd9; tick();
    chk("len1_rdy2", {31'd0, irl}, 32'd1);
    chk("len1_ov_gap", {31'd0, ovl}, 32'd0);
    tick();
    chk("len1_rdy3", {31'd0, irl}, 32'd0);
    chk("len1_ov_b", {31'd0, ovl}, 32'd1);
    chk("len1_sum_b", {8'd0, sl}, 32'd9);
    vl = 1'b0; tick();
    chk("len1_idle", {31'd0, ovl}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
